// File: rtl/puf_eval_sequencer.sv
// Arbiter-PUF evaluation sequencer: holds one challenge on the delay-line selects,
// fires VOTES launch pulses with settle gaps and majority-votes the arbiter samples.
module puf_eval_sequencer #(
    parameter int C_LENGTH = 32,
    parameter int SETTLE   = 4,
    parameter int VOTES    = 5,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [C_LENGTH-1:0] challenge_in,
    input  logic                arb_resp,
    output logic [C_LENGTH-1:0] challenge_out,
    output logic                pulse_out,
    output logic                busy,
    output logic                done,
    output logic                response,
    output logic [CNT_W-1:0]    ones_count
);

    typedef enum logic [2:0] {IDLE, LOAD, FIRE, SAMPLE, RELAX, DONE} state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] VOTES_N     = CNT_W'(VOTES);
    localparam logic [CNT_W-1:0] MAJORITY    = CNT_W'(VOTES / 2);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      phase_q, phase_d;
    logic [CNT_W-1:0]      vote_q, vote_d;
    logic [CNT_W-1:0]      ones_q, ones_d;
    logic [C_LENGTH-1:0]   chal_q, chal_d;
    logic                  pulse_q, pulse_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  resp_q, resp_d;
    logic                  phase_last;

    assign phase_last = (phase_q == SETTLE_LAST);

    // Outputs are loaded on the transition into each state so they line up with it.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        vote_d  = vote_q;
        ones_d  = ones_q;
        chal_d  = chal_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        resp_d  = resp_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d  = challenge_in;
                    ones_d  = '0;
                    vote_d  = '0;
                    phase_d = '0;
                    busy_d  = 1'b1;
                    pulse_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (phase_last) begin
                    phase_d = '0;
                    pulse_d = 1'b1;
                    state_d = FIRE;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            FIRE: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = SAMPLE;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                ones_d  = ones_q + CNT_W'(arb_resp);
                vote_d  = vote_q + CNT_W'(1);
                pulse_d = 1'b0;
                state_d = RELAX;
            end
            RELAX: begin
                if (phase_last) begin
                    phase_d = '0;
                    if (vote_q == VOTES_N) begin
                        done_d  = 1'b1;
                        resp_d  = (ones_q > MAJORITY);
                        state_d = DONE;
                    end else begin
                        pulse_d = 1'b1;
                        state_d = FIRE;
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            vote_q  <= '0;
            ones_q  <= '0;
            chal_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            vote_q  <= vote_d;
            ones_q  <= ones_d;
            chal_q  <= chal_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            resp_q  <= resp_d;
        end
    end

    assign challenge_out = chal_q;
    assign pulse_out     = pulse_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign response      = resp_q;
    assign ones_count    = ones_q;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed bench for puf_eval_sequencer: default-parameter instance plus a
// VOTES=1/SETTLE=1 instance for the continuous-start case.
module tb_puf_eval_sequencer;

    localparam int S  = 4;
    localparam int V  = 5;
    localparam int L  = S + V * (2 * S + 1) + 1;
    localparam int S2 = 1;
    localparam int V2 = 1;
    localparam int L2 = S2 + V2 * (2 * S2 + 1) + 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, arb_resp;
    logic [31:0] challenge_in, challenge_out;
    logic        pulse_out, busy, done, response;
    logic [7:0]  ones_count;

    logic        rst2, start2, arb2;
    logic [31:0] challenge_out2;
    logic        pulse2, busy2, done2, response2;
    logic [7:0]  ones2;

    int checks = 0;
    int errors = 0;

    int          r_done_at, r_done_cnt, r_pulse_err, r_rises, r_ch_changed;
    logic        r_acc_busy, r_resp, r_end_busy;
    logic [7:0]  r_acc_ones, r_ones;

    puf_eval_sequencer #(.C_LENGTH(32), .SETTLE(S), .VOTES(V), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge_in(challenge_in),
        .arb_resp(arb_resp), .challenge_out(challenge_out), .pulse_out(pulse_out),
        .busy(busy), .done(done), .response(response), .ones_count(ones_count)
    );

    puf_eval_sequencer #(.C_LENGTH(32), .SETTLE(S2), .VOTES(V2), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .challenge_in(32'hDEAD_BEEF),
        .arb_resp(arb2), .challenge_out(challenge_out2), .pulse_out(pulse2),
        .busy(busy2), .done(done2), .response(response2), .ones_count(ones2)
    );

    // Observed #1 after edge k following the accept: LOAD for S cycles, then per vote
    // S FIRE + 1 SAMPLE cycles high and S RELAX cycles low.
    function automatic logic exp_pulse(input int k);
        int m, j;
        if (k < S) return 1'b0;
        m = (k - S) % (2 * S + 1);
        j = (k - S) / (2 * S + 1);
        return (j < V) && (m <= S);
    endfunction

    // pat bit i is the arbiter value presented during launch i; glitch mode holds
    // arb_resp high everywhere except the SAMPLE cycles.
    task automatic run_eval(input logic [31:0] ch, input logic [4:0] pat,
                            input bit glitch, input int restart_at);
        int   idx;
        logic prev;
        idx = 0;
        prev = 1'b0;
        r_done_at = -1;
        r_done_cnt = 0;
        r_pulse_err = 0;
        r_rises = 0;
        r_ch_changed = 0;
        @(negedge clk);
        start = 1'b1;
        challenge_in = ch;
        arb_resp = glitch;
        @(posedge clk);
        #1;
        start = 1'b0;
        r_acc_busy = busy;
        r_acc_ones = ones_count;
        for (int k = 1; k <= L + 3; k++) begin
            @(posedge clk);
            #1;
            if (start) start = 1'b0;
            if (pulse_out !== exp_pulse(k)) r_pulse_err++;
            if (pulse_out === 1'b1 && prev === 1'b0) begin
                r_rises++;
                if (!glitch && idx < V) begin
                    arb_resp = pat[idx];
                    idx++;
                end
            end
            if (glitch) arb_resp = (k >= 2 * S && (k - 2 * S) % (2 * S + 1) == 0) ? 1'b0 : 1'b1;
            if (challenge_out !== ch) r_ch_changed++;
            if (done === 1'b1) begin
                r_done_cnt++;
                if (r_done_at < 0) r_done_at = k;
            end
            if (k == restart_at) begin
                start = 1'b1;
                challenge_in = 32'h1234_5678;
            end
            prev = pulse_out;
        end
        r_ones = ones_count;
        r_resp = response;
        r_end_busy = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rst2 = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        arb_resp = 1'b0;
        arb2 = 1'b0;
        challenge_in = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (challenge_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_challenge: got %h expected 0", challenge_out); end
        checks++; if (pulse_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse: got %b expected 0", pulse_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (response !== 1'b0) begin errors++; $display("[TB] FAIL reset_response: got %b expected 0", response); end
        checks++; if (ones_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_ones: got %0d expected 0", ones_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // done is high at edge L, i.e. visible just after edge L-1.
    task automatic test_all_ones();
        run_eval(32'hA5A5_F00F, 5'b11111, 1'b0, -1);
        checks++; if (r_acc_busy !== 1'b1) begin errors++; $display("[TB] FAIL t1_busy_on_accept: got %b expected 1", r_acc_busy); end
        checks++; if (r_ch_changed != 0) begin errors++; $display("[TB] FAIL t1_challenge_held: got %0d bad cycles expected 0", r_ch_changed); end
        checks++; if (r_done_at != L - 1) begin errors++; $display("[TB] FAIL t1_latency: got %0d expected %0d", r_done_at, L - 1); end
        checks++; if (r_done_cnt != 1) begin errors++; $display("[TB] FAIL t1_done_count: got %0d expected 1", r_done_cnt); end
        checks++; if (r_ones !== 8'd5) begin errors++; $display("[TB] FAIL t1_ones: got %0d expected 5", r_ones); end
        checks++; if (r_resp !== 1'b1) begin errors++; $display("[TB] FAIL t1_response: got %b expected 1", r_resp); end
        checks++; if (r_pulse_err != 0) begin errors++; $display("[TB] FAIL t1_pulse_shape: got %0d bad cycles expected 0", r_pulse_err); end
        checks++; if (r_rises != V) begin errors++; $display("[TB] FAIL t1_pulse_count: got %0d expected %0d", r_rises, V); end
        checks++; if (r_end_busy !== 1'b0) begin errors++; $display("[TB] FAIL t1_busy_after_done: got %b expected 0", r_end_busy); end
    endtask

    task automatic test_vote_patterns();
        run_eval(32'h0000_00FF, 5'b00101, 1'b0, -1);
        checks++; if (r_acc_ones !== 8'd0) begin errors++; $display("[TB] FAIL t2_ones_cleared: got %0d expected 0", r_acc_ones); end
        checks++; if (r_ones !== 8'd2) begin errors++; $display("[TB] FAIL t2a_ones: got %0d expected 2", r_ones); end
        checks++; if (r_resp !== 1'b0) begin errors++; $display("[TB] FAIL t2a_response: got %b expected 0", r_resp); end
        run_eval(32'h8000_0001, 5'b01011, 1'b0, -1);
        checks++; if (r_ones !== 8'd3) begin errors++; $display("[TB] FAIL t2b_ones: got %0d expected 3", r_ones); end
        checks++; if (r_resp !== 1'b1) begin errors++; $display("[TB] FAIL t2b_response: got %b expected 1", r_resp); end
        checks++; if (r_done_at != L - 1) begin errors++; $display("[TB] FAIL t2b_latency: got %0d expected %0d", r_done_at, L - 1); end
    endtask

    task automatic test_start_while_busy();
        run_eval(32'hA5A5_F00F, 5'b11111, 1'b0, 10);
        checks++; if (r_ch_changed != 0) begin errors++; $display("[TB] FAIL t3_challenge_held: got %0d bad cycles expected 0", r_ch_changed); end
        checks++; if (r_done_cnt != 1) begin errors++; $display("[TB] FAIL t3_done_count: got %0d expected 1", r_done_cnt); end
        checks++; if (r_done_at != L - 1) begin errors++; $display("[TB] FAIL t3_latency: got %0d expected %0d", r_done_at, L - 1); end
    endtask

    task automatic test_reset_mid_eval();
        int bad;
        @(negedge clk);
        start = 1'b1;
        challenge_in = 32'hCAFE_0001;
        arb_resp = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            @(posedge clk);
            #1;
        end
        checks++; if (pulse_out !== 1'b1) begin errors++; $display("[TB] FAIL t4_in_fire: got %b expected 1", pulse_out); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (pulse_out !== 1'b0) begin errors++; $display("[TB] FAIL t4_pulse: got %b expected 0", pulse_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t4_busy: got %b expected 0", busy); end
        checks++; if (ones_count !== 8'd0) begin errors++; $display("[TB] FAIL t4_ones: got %0d expected 0", ones_count); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL t4_done: got %b expected 0", done); end
        checks++; if (challenge_out !== 32'h0) begin errors++; $display("[TB] FAIL t4_challenge: got %h expected 0", challenge_out); end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL t4_quiet_after_reset: got %0d bad cycles expected 0", bad); end
        run_eval(32'h0F0F_1234, 5'b11111, 1'b0, -1);
        checks++; if (r_done_at != L - 1) begin errors++; $display("[TB] FAIL t4_fresh_latency: got %0d expected %0d", r_done_at, L - 1); end
        checks++; if (r_ones !== 8'd5) begin errors++; $display("[TB] FAIL t4_fresh_ones: got %0d expected 5", r_ones); end
    endtask

    task automatic test_back_to_back();
        int dt[$];
        int run, low_runs, low_bad, resp_bad;
        run = 0;
        low_runs = 0;
        low_bad = 0;
        resp_bad = 0;
        @(negedge clk);
        rst2 = 1'b0;
        start2 = 1'b1;
        arb2 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done2 === 1'b1) begin
                dt.push_back(k);
                if (response2 !== 1'b1 || ones2 !== 8'd1) resp_bad++;
            end
            if (busy2 === 1'b0) begin
                run++;
            end else begin
                if (dt.size() > 0 && run > 0) begin
                    low_runs++;
                    if (run != 1) low_bad++;
                end
                run = 0;
            end
        end
        checks++;
        if (dt.size() < 3) begin
            errors++;
            $display("[TB] FAIL t5_done_strobes: got %0d expected at least 3", dt.size());
        end else begin
            checks++; if (dt[1] - dt[0] != L2 + 1) begin errors++; $display("[TB] FAIL t5_period1: got %0d expected %0d", dt[1] - dt[0], L2 + 1); end
            checks++; if (dt[2] - dt[1] != L2 + 1) begin errors++; $display("[TB] FAIL t5_period2: got %0d expected %0d", dt[2] - dt[1], L2 + 1); end
        end
        checks++; if (resp_bad != 0) begin errors++; $display("[TB] FAIL t5_response: got %0d bad strobes expected 0", resp_bad); end
        checks++; if (low_runs < 2 || low_bad != 0) begin errors++; $display("[TB] FAIL t5_busy_gap: got %0d runs %0d bad expected >=2 runs 0 bad", low_runs, low_bad); end
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic test_sample_only();
        run_eval(32'h5555_AAAA, 5'b00000, 1'b1, -1);
        checks++; if (r_ones !== 8'd0) begin errors++; $display("[TB] FAIL t6_ones: got %0d expected 0", r_ones); end
        checks++; if (r_resp !== 1'b0) begin errors++; $display("[TB] FAIL t6_response: got %b expected 0", r_resp); end
        checks++; if (r_done_cnt != 1) begin errors++; $display("[TB] FAIL t6_done_count: got %0d expected 1", r_done_cnt); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_vote_patterns();
        test_start_while_busy();
        test_reset_mid_eval();
        test_back_to_back();
        test_sample_only();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
